// File: rtl/rf_writeback_pkg.sv
// Shared core types for the register-file write-back slice.
package rf_writeback_pkg;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_REGS  = 2 ** REG_IDX_W;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/rf_writeback_if.sv
// Pipeline, long-latency, decode and register-file signals of the write-back block.
interface rf_writeback_if;
  import rf_writeback_pkg::*;

  logic                 pipe_valid;
  logic [REG_IDX_W-1:0] pipe_rd;
  logic [XLEN-1:0]      pipe_data;
  logic                 long_valid;
  logic                 long_ready;
  logic [REG_IDX_W-1:0] long_rd;
  logic [XLEN-1:0]      long_data;
  logic                 issue_en;
  logic [REG_IDX_W-1:0] issue_rd;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 issue_busy;
  logic                 pipe_hold;
  logic                 err;
  logic                 rf_wr_en;
  logic [REG_IDX_W-1:0] rf_rd;
  logic [XLEN-1:0]      rf_wr_data;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, long_valid, long_rd, long_data,
           issue_en, issue_rd, rs1, rs2,
    input  long_ready, rs1_busy, rs2_busy, issue_busy, pipe_hold, err,
           rf_wr_en, rf_rd, rf_wr_data
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, long_valid, long_rd, long_data,
           issue_en, issue_rd, rs1, rs2,
    output long_ready, rs1_busy, rs2_busy, issue_busy, pipe_hold, err,
           rf_wr_en, rf_rd, rf_wr_data
  );
endinterface

// File: rtl/rf_writeback_wb_fifo.sv
// Synchronous FIFO of write-back entries with async reset; head is read combinationally.
module wb_fifo
  import rf_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  wb_entry_t                  din,
  output wb_entry_t                  dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/rf_writeback.sv
// Write-back arbiter: merges pipeline and long-latency results onto the single RF write
// port and keeps the pending-destination scoreboard used by decode for hazard stalls.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  rf_writeback_if.slave wb
);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  wb_entry_t                    head;
  wb_entry_t                    push_entry;
  wb_entry_t                    sel;
  logic                         sel_valid;
  logic                         full;
  logic                         empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         push;
  logic                         pop;
  logic [NUM_REGS-1:0]          busy;
  logic [NUM_REGS-1:0]          busy_next;
  logic [CW-1:0]                starve_cnt;
  logic [CW-1:0]                starve_next;
  logic                         hold_q;
  logic                         err_q;
  logic                         err_hit;

  // long_ready uses the pre-pop full flag, so a full FIFO refuses a push even while popping.
  assign wb.long_ready = ~rst & ~full;
  assign push          = wb.long_valid & wb.long_ready;
  assign pop           = ~wb.pipe_valid & ~empty;
  assign push_entry    = '{rd: wb.long_rd, data: wb.long_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel       = head;
    if (wb.pipe_valid) begin
      sel_valid = 1'b1;
      sel       = '{rd: wb.pipe_rd, data: wb.pipe_data};
    end else if (pop) begin
      sel_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb.rf_wr_en   <= 1'b0;
      wb.rf_rd      <= '0;
      wb.rf_wr_data <= '0;
    end else begin
      wb.rf_wr_en <= sel_valid && (sel.rd != '0);
      if (sel_valid) begin
        wb.rf_rd      <= sel.rd;
        wb.rf_wr_data <= sel.data;
      end
    end
  end

  // Clear on the head pop coincides with rf_wr_en rising; a same-cycle issue re-sets the bit.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head.rd] = 1'b0;
    if (wb.issue_en && (wb.issue_rd != '0)) busy_next[wb.issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  assign wb.rs1_busy   = busy[wb.rs1] & (wb.rs1 != '0);
  assign wb.rs2_busy   = busy[wb.rs2] & (wb.rs2 != '0);
  assign wb.issue_busy = busy[wb.issue_rd] & (wb.issue_rd != '0);

  always_comb begin
    if ((fifo_count == '0) || pop) begin
      starve_next = '0;
    end else if (starve_cnt < STARVE_LIM) begin
      starve_next = starve_cnt + CW'(1);
    end else begin
      starve_next = starve_cnt;
    end
  end

  assign err_hit = (wb.issue_en & wb.issue_busy) | (push & full) | (wb.pipe_valid & hold_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      starve_cnt <= '0;
      hold_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      busy       <= busy_next;
      starve_cnt <= starve_next;
      hold_q     <= (starve_next >= STARVE_LIM);
      err_q      <= err_q | err_hit;
    end
  end

  assign wb.pipe_hold = hold_q;
  assign wb.err       = err_q;
endmodule
